r_instr_encoder: RTL

R_INSTR_ENCODER -- requirements
Module: r_instr_encoder

---
 rtl/mips_r_pkg.sv | 46 ++++
 rtl/r_instr_encoder_if.sv | 27 ++
 rtl/r_instr_fifo.sv | 60 ++++++
 rtl/r_instr_encoder.sv | 68 ++++++
 4 files changed

// File: rtl/mips_r_pkg.sv
// Shared definitions for MIPS R-type encoding: ALU control codes, funct
// values, opcode and instruction field positions.
package mips_r_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    // Codes above SLT are reserved and must never reach the instruction stream.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= ALU_SLT;
    endfunction

    function automatic logic [5:0] funct_of(input logic [2:0] op);
        logic [5:0] f;
        case (op)
            ALU_ADD: f = FUNCT_ADD;
            ALU_SUB: f = FUNCT_SUB;
            ALU_AND: f = FUNCT_AND;
            ALU_OR:  f = FUNCT_OR;
            ALU_SLT: f = FUNCT_SLT;
            default: f = 6'b000000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/r_instr_encoder_if.sv
// Request/response bundle between an instruction producer and the R-type
// encoder; the master issues ALU requests and consumes encoded words.
interface r_instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_illegal;
    logic [15:0] issued_cnt;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, out_ready,
        input  in_ready, out_valid, out_instr, err_illegal, issued_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, out_ready,
        output in_ready, out_valid, out_instr, err_illegal, issued_cnt
    );

endinterface

// File: rtl/r_instr_fifo.sv
// Power-of-two circular buffer with occupancy counter; pointers wrap
// naturally because DEPTH is a power of two.
module r_instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            // A simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/r_instr_encoder.sv
// Encodes ALU requests into MIPS R-type words, buffers them in a FIFO and
// counts words consumed downstream; illegal codes are flagged and dropped.
module r_instr_encoder
    import mips_r_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    r_instr_encoder_if.slave    bus
);

    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] word;
    logic [31:0] head;

    assign legal  = is_legal_op(bus.in_op);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        word                      = '0;
        word[OPC_LSB +: 6]        = OPCODE_RTYPE;
        word[RS_LSB +: 5]         = bus.in_rs;
        word[RT_LSB +: 5]         = bus.in_rt;
        word[RD_LSB +: 5]         = bus.in_rd;
        word[SHAMT_LSB +: 5]      = 5'b00000;
        word[FUNCT_LSB +: 6]      = funct_of(bus.in_op);
    end

    r_instr_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Empty FIFO shows zero so a reset or drain never exposes stale storage.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'd0 : head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_illegal <= 1'b0;
            bus.issued_cnt  <= 16'd0;
        end else begin
            bus.err_illegal <= accept && !legal;
            if (pop) begin
                bus.issued_cnt <= bus.issued_cnt + 16'd1;
            end
        end
    end

endmodule
